// File: rtl/vga_scanout_if.sv
// vga_scanout_if: framebuffer read port plus VGA DAC outputs of vga_scanout.
// test_pattern exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_scanout_if;
    logic [7:0]  pixel_in;
    logic [10:0] rd_x;
    logic [10:0] rd_y;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        VGA_SYNC_N;
    logic        VGA_CLK;
    logic        frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_pattern;

    modport master (
        input  pixel_in, test_pattern,
        output rd_x, rd_y, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start
    );

    modport slave (
        output pixel_in, test_pattern,
        input  rd_x, rd_y, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start
    );
`else
    modport master (
        input  pixel_in,
        output rd_x, rd_y, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start
    );

    modport slave (
        output pixel_in,
        input  rd_x, rd_y, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start
    );
`endif
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA scanout of an RGB332 framebuffer, 25 MHz tick from CLOCK_50.
// Define VGA_TEST_PATTERN_EN to add the test_pattern colour-bar input.
module vga_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input logic           CLOCK_50,
    input logic           reset,
    vga_scanout_if.master bus
);

    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic        r_ph;
    logic [10:0] r_hCnt;
    logic [10:0] r_vCnt;
    logic [10:0] r_rdX;
    logic [10:0] r_rdY;
    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic [7:0]  r_blue;
    logic        r_hSyncN;
    logic        r_vSyncN;
    logic        r_blankN;
    logic        r_frameStart;

    logic        w_tick;
    logic [10:0] w_hNext;
    logic [10:0] w_vNext;
    logic        w_active;
    logic        w_hSyncN;
    logic        w_vSyncN;
    logic [7:0]  w_pixel;

    assign w_tick = r_ph;

    always_comb begin
        w_hNext = r_hCnt + 11'd1;
        w_vNext = r_vCnt;
        if (r_hCnt == H_LAST) begin
            w_hNext = '0;
            w_vNext = (r_vCnt == V_LAST) ? '0 : r_vCnt + 11'd1;
        end
    end

    // Decode uses the pre-update counters, matching the pixel whose data arrives now
    assign w_active = (r_hCnt < H_ACT) && (r_vCnt < V_ACT);
    assign w_hSyncN = !((r_hCnt >= HS_START) && (r_hCnt < HS_END));
    assign w_vSyncN = !((r_vCnt >= VS_START) && (r_vCnt < VS_END));

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] w_bar;
    logic [7:0] w_barPixel;

    always_comb begin
        w_bar = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (r_hCnt < 11'((i + 1) * 80)) w_bar = 3'(i);
        end
    end

    // Bars are full-scale RGB332 values so they share the normal expansion path
    always_comb begin
        w_barPixel = 8'h00;
        case (w_bar)
            3'd0: w_barPixel = 8'hFF;
            3'd1: w_barPixel = 8'hFC;
            3'd2: w_barPixel = 8'h1F;
            3'd3: w_barPixel = 8'h1C;
            3'd4: w_barPixel = 8'hE3;
            3'd5: w_barPixel = 8'hE0;
            3'd6: w_barPixel = 8'h03;
            default: w_barPixel = 8'h00;
        endcase
    end

    assign w_pixel = bus.test_pattern ? w_barPixel : bus.pixel_in;
`else
    assign w_pixel = bus.pixel_in;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_ph         <= 1'b0;
            r_hCnt       <= '0;
            r_vCnt       <= '0;
            r_rdX        <= '0;
            r_rdY        <= '0;
            r_red        <= '0;
            r_green      <= '0;
            r_blue       <= '0;
            r_hSyncN     <= 1'b1;
            r_vSyncN     <= 1'b1;
            r_blankN     <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_ph         <= ~r_ph;
            r_frameStart <= 1'b0;
            if (w_tick) begin
                r_hCnt       <= w_hNext;
                r_vCnt       <= w_vNext;
                r_rdX        <= (w_hNext < H_ACT) ? w_hNext : '0;
                r_rdY        <= (w_vNext < V_ACT) ? w_vNext : '0;
                r_hSyncN     <= w_hSyncN;
                r_vSyncN     <= w_vSyncN;
                r_blankN     <= w_active;
                r_frameStart <= (r_hCnt == '0) && (r_vCnt == '0);
                if (w_active) begin
                    r_red   <= {w_pixel[7:5], w_pixel[7:5], w_pixel[7:6]};
                    r_green <= {w_pixel[4:2], w_pixel[4:2], w_pixel[4:3]};
                    r_blue  <= {w_pixel[1:0], w_pixel[1:0], w_pixel[1:0], w_pixel[1:0]};
                end else begin
                    r_red   <= '0;
                    r_green <= '0;
                    r_blue  <= '0;
                end
            end
        end
    end

    assign bus.rd_x        = r_rdX;
    assign bus.rd_y        = r_rdY;
    assign bus.VGA_R       = r_red;
    assign bus.VGA_G       = r_green;
    assign bus.VGA_B       = r_blue;
    assign bus.VGA_HS      = r_hSyncN;
    assign bus.VGA_VS      = r_vSyncN;
    assign bus.VGA_BLANK_N = r_blankN;
    assign bus.VGA_SYNC_N  = 1'b0;
    assign bus.VGA_CLK     = r_ph;
    assign bus.frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: full-size and shrunken-timing vga_scanout instances checked every clock
// against a pixel-index model of the raster; framebuffers are modelled with one-clock latency.
module tb_vga_scanout;

    localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
    localparam int S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 1;

    typedef struct packed {
        logic [10:0] rdX;
        logic [10:0] rdY;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs;
        logic        vs;
        logic        blankN;
        logic        syncN;
        logic        vgaClk;
        logic        frameStart;
    } outs_t;

    logic CLOCK_50 = 1'b0;
    logic reset;

    vga_scanout_if fullIf ();
    vga_scanout_if smallIf ();

    vga_scanout dutFull (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (fullIf)
    );

    vga_scanout #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
    ) dutSmall (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (smallIf)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int compared = 0;
    int mismatched = 0;
    int n = 0;
    bit nValid = 0;
    int fullMode = 1, fullSeed = 0, smallMode = 0, smallSeed = 0;
    bit tpVal = 0;

    int hsFalls[$];
    int hsRises[$];
    int fsTimes[$];
    int blankCount = 0;
    logic prevHs = 1'b1;
    int maxFullRdX = 0, maxSmallRdX = 0, maxSmallRdY = 0;

`ifdef VGA_TEST_PATTERN_EN
    assign fullIf.test_pattern  = tpVal;
    assign smallIf.test_pattern = 1'b0;
`endif

    function automatic logic [7:0] bufPixel(int mode, int seed, int x, int y);
        if (mode == 1) return (x == 0) ? 8'hE0 : 8'h03;
        return 8'((x * 37) ^ (y * 101) ^ seed);
    endfunction

    // Framebuffer models: data appears one clock after the address
    always @(posedge CLOCK_50) begin
        fullIf.pixel_in  <= bufPixel(fullMode, fullSeed, int'(fullIf.rd_x), int'(fullIf.rd_y));
        smallIf.pixel_in <= bufPixel(smallMode, smallSeed, int'(smallIf.rd_x), int'(smallIf.rd_y));
    end

    always @(posedge CLOCK_50) begin
        if (!reset) begin
            n      <= 0;
            nValid <= 1'b1;
        end else begin
            n <= n + 1;
        end
    end

    function automatic logic [23:0] barRgb(int h);
        case (h / 80)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // n clocks after reset release: j = n/2 ticks done, outputs show pixel j-1, rd shows pixel j
    function automatic outs_t model(int cyc, int hA, int hF, int hS, int hB,
                                    int vA, int vF, int vS, int vB,
                                    int mode, int seed, bit tp);
        outs_t o;
        int hT, vT, frame, j, rp, p, h, v;
        logic [7:0] pix;
        hT = hA + hF + hS + hB;
        vT = vA + vF + vS + vB;
        frame = hT * vT;
        j = cyc / 2;
        rp = j % frame;
        o = '0;
        o.rdX = 11'(((rp % hT) < hA) ? (rp % hT) : 0);
        o.rdY = 11'(((rp / hT) < vA) ? (rp / hT) : 0);
        o.vgaClk = (cyc % 2) == 1;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (j > 0) begin
            p = (j - 1) % frame;
            h = p % hT;
            v = p / hT;
            o.hs = !(h >= hA + hF && h < hA + hF + hS);
            o.vs = !(v >= vA + vF && v < vA + vF + vS);
            o.blankN = (h < hA) && (v < vA);
            o.frameStart = (p == 0) && ((cyc % 2) == 0);
            if (o.blankN) begin
                if (tp) begin
                    {o.r, o.g, o.b} = barRgb(h);
                end else begin
                    pix = bufPixel(mode, seed, h, v);
                    o.r = {pix[7:5], pix[7:5], pix[7:6]};
                    o.g = {pix[4:2], pix[4:2], pix[4:3]};
                    o.b = {pix[1:0], pix[1:0], pix[1:0], pix[1:0]};
                end
            end
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at n=%0d: got %h, want %h", name, n, act, exp);
        end
    endtask

    outs_t fullObs, smallObs;
    assign fullObs = {fullIf.rd_x, fullIf.rd_y, fullIf.VGA_R, fullIf.VGA_G, fullIf.VGA_B,
                      fullIf.VGA_HS, fullIf.VGA_VS, fullIf.VGA_BLANK_N, fullIf.VGA_SYNC_N,
                      fullIf.VGA_CLK, fullIf.frame_start};
    assign smallObs = {smallIf.rd_x, smallIf.rd_y, smallIf.VGA_R, smallIf.VGA_G, smallIf.VGA_B,
                       smallIf.VGA_HS, smallIf.VGA_VS, smallIf.VGA_BLANK_N, smallIf.VGA_SYNC_N,
                       smallIf.VGA_CLK, smallIf.frame_start};

    always @(negedge CLOCK_50) begin
        if (nValid) begin
            checkOutput("fullOuts", fullObs,
                        model(n, 640, 16, 96, 48, 480, 10, 2, 33, fullMode, fullSeed, tpVal));
            checkOutput("smallOuts", smallObs,
                        model(n, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB,
                              smallMode, smallSeed, 1'b0));
        end
    end

    always @(negedge CLOCK_50) begin
        if (nValid) begin
            if (prevHs === 1'b1 && fullIf.VGA_HS === 1'b0) hsFalls.push_back(n);
            if (prevHs === 1'b0 && fullIf.VGA_HS === 1'b1) hsRises.push_back(n);
            prevHs = fullIf.VGA_HS;
            if (reset && n >= 2 && n <= 1601 && fullIf.VGA_BLANK_N === 1'b1) blankCount++;
            if (smallIf.frame_start === 1'b1) fsTimes.push_back(n);
            if (int'(fullIf.rd_x) > maxFullRdX) maxFullRdX = int'(fullIf.rd_x);
            if (int'(smallIf.rd_x) > maxSmallRdX) maxSmallRdX = int'(smallIf.rd_x);
            if (int'(smallIf.rd_y) > maxSmallRdY) maxSmallRdY = int'(smallIf.rd_y);
        end
    end

    task automatic waitN(input int target);
        int k = 0;
        while (n < target && k < 100000) begin
            @(negedge CLOCK_50);
            k++;
        end
        if (n != target) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL waitN: got n=%0d, want %0d", n, target);
        end
    endtask

    // Holds reset, then loads new buffer/test-pattern settings while the outputs sit at reset values
    task automatic applyStimulus(input int hold, input int fMode, input int fSeed,
                                 input int sMode, input int sSeed, input bit tp, input bit checkReset);
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (hold) @(negedge CLOCK_50);
        if (checkReset) begin
            checkOutput("resetHs", 64'(fullIf.VGA_HS), 64'd1);
            checkOutput("resetVs", 64'(fullIf.VGA_VS), 64'd1);
            checkOutput("resetBlank", 64'(fullIf.VGA_BLANK_N), 64'd0);
            checkOutput("resetRgb", 64'({fullIf.VGA_R, fullIf.VGA_G, fullIf.VGA_B}), 64'd0);
            checkOutput("resetRd", 64'({fullIf.rd_x, fullIf.rd_y}), 64'd0);
            checkOutput("resetFs", 64'(fullIf.frame_start), 64'd0);
        end
        fullMode = fMode;
        fullSeed = fSeed;
        smallMode = sMode;
        smallSeed = sSeed;
        tpVal = tp;
        hsFalls.delete();
        hsRises.delete();
        fsTimes.delete();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(4, 1, 0, 0, int'($urandom_range(0, 255)), 1'b0, 1'b1);

        @(negedge CLOCK_50);
        checkOutput("edge1Clk", 64'(fullIf.VGA_CLK), 64'd1);
        checkOutput("edge1Fs", 64'(fullIf.frame_start), 64'd0);
        @(negedge CLOCK_50);
        checkOutput("tick1Fs", 64'(fullIf.frame_start), 64'd1);
        checkOutput("pix0Rgb", 64'({fullIf.VGA_R, fullIf.VGA_G, fullIf.VGA_B}), 64'hFF0000);
        @(negedge CLOCK_50);
        checkOutput("edge3Fs", 64'(fullIf.frame_start), 64'd0);
        @(negedge CLOCK_50);
        checkOutput("pix1Rgb", 64'({fullIf.VGA_R, fullIf.VGA_G, fullIf.VGA_B}), 64'h0000FF);
        waitN(1402);
        checkOutput("blankRgb", 64'({fullIf.VGA_R, fullIf.VGA_G, fullIf.VGA_B}), 64'd0);
        checkOutput("blankN", 64'(fullIf.VGA_BLANK_N), 64'd0);

        waitN(3300);
        checkOutput("hsFallCount", 64'(hsFalls.size()), 64'd2);
        checkOutput("hsRiseCount", 64'(hsRises.size()), 64'd2);
        if (hsFalls.size() >= 2 && hsRises.size() >= 1) begin
            checkOutput("hsFirstFall", 64'(hsFalls[0]), 64'd1314);
            checkOutput("hsLowWidth", 64'(hsRises[0] - hsFalls[0]), 64'd192);
            checkOutput("hsPeriod", 64'(hsFalls[1] - hsFalls[0]), 64'd1600);
        end
        checkOutput("blankHighLine0", 64'(blankCount), 64'd1280);
        checkOutput("smallFsCount", 64'(fsTimes.size()), 64'd7);
        if (fsTimes.size() >= 2) begin
            checkOutput("smallFsFirst", 64'(fsTimes[0]), 64'd2);
            checkOutput("smallFsPeriod", 64'(fsTimes[1] - fsTimes[0]), 64'd500);
        end
        checkOutput("fullMaxRdX", 64'(maxFullRdX), 64'd639);
        checkOutput("smallMaxRdX", 64'(maxSmallRdX), 64'd15);
        checkOutput("smallMaxRdY", 64'(maxSmallRdY), 64'd5);

        // Mid-frame reset for a single clock
        waitN(3300 + int'($urandom_range(1, 400)));
        applyStimulus(1, 0, int'($urandom_range(0, 255)), 0, int'($urandom_range(0, 255)), 1'b0, 1'b1);
        waitN(1100);
        checkOutput("restartFsCount", 64'(fsTimes.size()), 64'd3);
        if (fsTimes.size() >= 2) begin
            checkOutput("restartFsFirst", 64'(fsTimes[0]), 64'd2);
            checkOutput("restartFsPeriod", 64'(fsTimes[1] - fsTimes[0]), 64'd500);
        end

        for (int it = 0; it < 3; it++) begin
            applyStimulus(int'($urandom_range(1, 3)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 255)), 0, int'($urandom_range(0, 255)), 1'b0, 1'b0);
            waitN(int'($urandom_range(200, 2000)));
        end

`ifdef VGA_TEST_PATTERN_EN
        applyStimulus(2, 0, int'($urandom_range(0, 255)), 0, int'($urandom_range(0, 255)), 1'b1, 1'b0);
        waitN(172);
        checkOutput("barYellowH85", 64'({fullIf.VGA_R, fullIf.VGA_G, fullIf.VGA_B}), 64'hFFFF00);
        waitN(332);
        checkOutput("barCyanH165", 64'({fullIf.VGA_R, fullIf.VGA_G, fullIf.VGA_B}), 64'h00FFFF);
        waitN(1280);
        checkOutput("barBlackH639", 64'({fullIf.VGA_R, fullIf.VGA_G, fullIf.VGA_B}), 64'h000000);
        checkOutput("barBlankH639", 64'(fullIf.VGA_BLANK_N), 64'd1);
        waitN(1400);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
